// File: rtl/instr_encoder.sv
// Symbolic RV32I request (addi/bne/nop) to machine-word encoder with a single
// registered write stage toward instruction memory. Tracks fill level and first error.
module instr_encoder #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BASE_ADDR  = 0,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [12:0]           in_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [CW-1:0]         word_count,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);

  localparam logic [1:0] OP_ADDI = 2'b00;
  localparam logic [1:0] OP_BNE  = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;

  localparam logic [1:0] E_ILLEGAL = 2'b01;
  localparam logic [1:0] E_RANGE   = 2'b10;
  localparam logic [1:0] E_ALIGN   = 2'b11;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [1:0]              err_code_q, err_code_d;

  logic [31:0] enc_word;
  logic        enc_ok;
  logic [1:0]  enc_code;

  always_comb begin
    enc_word = 32'h0000_0013;
    enc_ok   = 1'b1;
    enc_code = 2'b00;
    unique case (in_op)
      OP_ADDI: begin
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
        if (in_imm[12] != in_imm[11]) begin
          enc_ok   = 1'b0;
          enc_code = E_RANGE;
        end
      end
      OP_BNE: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                    in_imm[4:1], in_imm[11], 7'b1100011};
        if (in_imm[0]) begin
          enc_ok   = 1'b0;
          enc_code = E_ALIGN;
        end
      end
      OP_NOP: enc_word = 32'h0000_0013;
      default: begin
        enc_ok   = 1'b0;
        enc_code = E_ILLEGAL;
      end
    endcase
  end

  // Count already includes the pending write, so the limit check needs no lookahead.
  assign in_ready = (state_q == S_RUN) && !start && (count_q < DEPTH_C);

  // NOTE: every next-state signal gets its hold value first so no path leaves it
  // unassigned, which keeps this block purely combinational (no latches).
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    if (start) begin
      state_d    = S_RUN;
      ptr_d      = BASE_C;
      count_d    = '0;
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end else if (in_valid && in_ready) begin
      if (enc_ok) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = enc_word;
        ptr_d   = ptr_q + ADDR_WIDTH'(4);
        count_d = count_q + CW'(1);
        if (count_d == DEPTH_C) state_d = S_FULL;
      end else begin
        err_d = 1'b1;
        if (!err_q) err_code_d = enc_code;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= BASE_C;
      count_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_C;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign done       = (state_q == S_FULL);
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder (DEPTH=4) against a
// spec-level model of fill level, error latching and RV32I encodings.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned BASE  = 0;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [12:0]   in_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [CW-1:0] word_count;
  logic          done, err;
  logic [1:0]    err_code;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: fill level, pointer, error latch, pending write.
  bit          m_started;
  int          m_count;
  int unsigned m_ptr;
  bit          m_err;
  int          m_code;
  bit          m_we;
  int unsigned m_addr;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_encode(input logic [1:0] op, input logic [4:0] rd, rs1, rs2,
                                     input logic [12:0] imm, output bit ok,
                                     output logic [31:0] w, output int code);
    int          simm;
    logic [31:0] u;
    simm = int'($signed(imm));
    u    = 32'(imm);
    ok   = 1'b1;
    code = 0;
    w    = 32'h13;
    case (op)
      2'd0: begin
        ok   = (simm >= -2048) && (simm <= 2047);
        code = 2;
        w = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
      end
      2'd1: begin
        ok   = (simm % 2) == 0;
        code = 3;
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
          | (32'(rs1) << 15) | (32'd1 << 12) | (((u >> 1) & 32'hF) << 8)
          | (((u >> 11) & 1) << 7) | 32'h63;
      end
      2'd2: w = 32'h13;
      default: begin
        ok   = 1'b0;
        code = 1;
      end
    endcase
  endfunction

  function automatic void model_reset();
    m_started = 0; m_count = 0; m_ptr = BASE; m_err = 0; m_code = 0; m_we = 0;
  endfunction

  // One clock: inputs applied at negedge, outputs checked at the following negedge.
  task automatic step(input logic s, input logic v, input logic [1:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [12:0] imm);
    bit          exp_ready, ok;
    logic [31:0] w;
    int          code;
    start = s; in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    #1;
    exp_ready = m_started && !s && (m_count < DEPTH);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    ref_encode(op, rd, rs1, rs2, imm, ok, w, code);
    @(posedge clk);
    m_we = 0;
    if (s) begin
      m_started = 1; m_count = 0; m_ptr = BASE; m_err = 0; m_code = 0;
    end else if (v && exp_ready) begin
      if (ok) begin
        m_we = 1; m_addr = m_ptr; m_data = w; m_ptr += 4; m_count++;
      end else begin
        if (!m_err) m_code = code;
        m_err = 1;
      end
    end
    @(negedge clk);
    check("mem_we", 32'(mem_we), 32'(m_we));
    if (m_we) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_data);
    end
    check("word_count", 32'(word_count), 32'(m_count));
    check("done", 32'(done), 32'(m_started && m_count == DEPTH));
    check("err", 32'(err), 32'(m_err));
    check("err_code", 32'(err_code), 32'(m_code));
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 2'd2, 5'd0, 5'd0, 5'd0, 13'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, BASE);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_op = 2'd0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores requests until start.
    step(1'b0, 1'b1, 2'd2, 5'd0, 5'd0, 5'd0, 13'd0);

    // First addi.
    step(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    step(1'b0, 1'b1, 2'd0, 5'd1, 5'd0, 5'd0, 13'd5);
    check("addi_word", mem_wdata, 32'h0050_0093);
    check("addi_count", 32'(word_count), 32'd1);

    // Back-to-back after a restart.
    step(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    step(1'b0, 1'b1, 2'd0, 5'd2, 5'd2, 5'd0, 13'h1FFF);
    check("b2b_addi", mem_wdata, 32'hFFF1_0113);
    step(1'b0, 1'b1, 2'd1, 5'd0, 5'd1, 5'd0, 13'h1FF8);
    check("b2b_bne", mem_wdata, 32'hFE00_9CE3);
    check("b2b_bne_addr", mem_addr, 32'd4);
    step(1'b0, 1'b1, 2'd2, 5'd0, 5'd0, 5'd0, 13'd0);
    check("b2b_nop_addr", mem_addr, 32'd8);

    // Errors: first code held, no writes.
    step(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    step(1'b0, 1'b1, 2'd3, 5'd3, 5'd3, 5'd3, 13'd0);
    step(1'b0, 1'b1, 2'd0, 5'd1, 5'd1, 5'd0, 13'h0800);
    step(1'b0, 1'b1, 2'd1, 5'd0, 5'd1, 5'd2, 13'd3);
    check("err_first_code", 32'(err_code), 32'd1);

    // Fill: 6 continuous requests, only DEPTH written.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd2, 5'd0, 5'd0, 5'd0, 13'd0);
    check("full_count", 32'(word_count), DEPTH);
    check("full_done", 32'(done), 32'd1);

    // start wins over in_valid in FULL, then writing resumes at BASE.
    step(1'b1, 1'b1, 2'd2, 5'd0, 5'd0, 5'd0, 13'd0);
    step(1'b0, 1'b1, 2'd0, 5'd7, 5'd7, 5'd0, 13'd100);
    check("restart_addr", mem_addr, BASE);

    // Mid-stream reset with a pending write.
    start = 1'b0; in_valid = 1'b1; in_op = 2'd2;
    @(posedge clk);
    #2;
    check("pending_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 2'd2, 5'd0, 5'd0, 5'd0, 13'd0);
    idle_step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic        s, v;
      logic [12:0] imm;
      s = ($urandom % 8) == 0;
      v = ($urandom % 4) != 0;
      imm = 13'($urandom);
      if ($urandom % 2 == 0) imm = 13'($signed(12'($urandom)));
      step(s, v, 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
    end
    idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Turns symbolic instruction requests (op, rd, rs1, rs2, imm) into 32-bit RV32I machine words.
- Writes the words sequentially into instruction memory.
- It is the producer side of the decode path: it emits exactly the addi/bne/nop encodings the control unit decodes.
- Sits between the testbench or program-loader front end and the instruction memory write port; one-stage registered pipeline.

Parameters:
DEPTH, 256, number of 32-bit words in instruction memory (≥2)
ADDR_WIDTH, 32, width of byte address on memory write port
BASE_ADDR, 0, byte address of first word written after start

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: rewind address to BASE_ADDR, clear flags, enter RUN
in_valid  input  1  request valid
in_ready  output  1  encoder accepts request this cycle
in_op  input  2  00=addi, 01=bne, 10=nop, 11=illegal
in_rd  input  5  destination register (addi)
in_rs1  input  5  source 1 (addi, bne)
in_rs2  input  5  source 2 (bne)
in_imm  input  13  signed immediate: addi uses bits[11:0]; bne byte offset
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_WIDTH  byte address of write
mem_wdata  output  32  encoded instruction
word_count  output  $clog2(DEPTH+1)  words written since start
done  output  1  memory full (DEPTH words written)
err  output  1  sticky: at least one rejected request since start
err_code  output  2  first error: 01=illegal op, 10=addi imm out of range, 11=bne misaligned

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, done=0, err=0, err_code=0.
- States:
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready=1 unless the next write would exceed DEPTH.
  - FULL: in_ready=0, done=1. start -> RUN.
- Transfer: in_valid&in_ready in cycle N. If the request is legal, mem_we=1 in cycle N+1 with mem_wdata=encoding and mem_addr=current pointer. The pointer advances by 4 and word_count by 1 after the write. Throughput is 1 word/cycle. mem_we is a single-cycle strobe per word; no back-pressure from memory.
- Encodings (funct3 must match the decoder):
  - addi: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
  - bne: {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}.
  - nop: 32'h00000013.
  - Unused fields are ignored.
- Error checks on accepted requests:
  - op=11 -> illegal op.
  - addi with imm[12]≠imm[11] -> out of range.
  - bne with imm[0]=1 -> misaligned.
  - Rejected requests are consumed (handshake completes), produce no write and do not advance the pointer. err sets and stays set. err_code latches the first error only.
- Full: the DEPTH-th legal write sets done and moves to FULL in the same cycle mem_we is high. in_ready drops combinationally once word_count plus any pending write equals DEPTH, so no request is accepted beyond capacity.
- start in RUN or FULL: pointer, word_count, done, err and err_code clear on the next edge. in_ready=0 in the start cycle. A write already registered from the previous cycle still issues at its old address and is not counted after the restart.
- start with in_valid in the same cycle: start wins; the request is not accepted.
- rst_n asserted mid-operation: the pending write is discarded and mem_we is forced to 0 immediately.

Test Plan:
- Reset, start, send addi rd=1 rs1=0 imm=5 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00500093, word_count=1.
- Back-to-back: addi rd=2 rs1=2 imm=-1, bne rs1=1 rs2=0 imm=-8, nop -> three consecutive strobes at addr 0,4,8 with data 0xFFF10113, 0xFE009CE3, 0x00000013.
- Errors: op=11, then addi imm=13'h0800, then bne imm=3 -> no mem_we, pointer unchanged, err=1, err_code=01 (first error held).
- DEPTH=4: stream 6 valid requests continuously -> exactly 4 writes (addr 0..12), done=1 with the 4th strobe, in_ready=0 thereafter.
- In FULL, pulse start together with in_valid -> request not accepted. Next cycle done=0, word_count=0, err=0; the following request writes addr BASE_ADDR.
- Mid-stream rst_n low for 1 cycle with a pending write -> mem_we=0 immediately, all outputs at reset values, in_ready=0 until start.
